write_arbitrator_rr: RTL and testbench
======================================

// Module: write_arbitrator_rr
//
// PURPOSE
// - N-to-1 write arbiter between the solver cores and the frame-buffer write port.
// - Accepts one write per cycle from any solver. Writes queue in an output FIFO,
//   so memory back-pressure does not stall arbitration until the FIFO fills.
// - Successor to the two-state fixed-priority arbiter: widths, channel count and
//   buffer depth are parametrised, and round-robin fairness is a build option.
//
// PARAMETERS
// NUM_SOLVERS  4   number of requesting channels (>=1)
// DATA_W       16  write data width (pixel word)
// ADDR_W       32  write address width
// FIFO_DEPTH   4   output queue entries (power of 2, >=2)
//
// PORTS
// clock         in   1                 system clock
// reset         in   1                 reset, synchronous, active-high
// in_data       in   NUM_SOLVERS*DATA_W  per-channel write data, packed [NUM_SOLVERS-1:0][DATA_W-1:0]
// in_addr       in   NUM_SOLVERS*ADDR_W  per-channel write address, packed likewise
// in_valid      in   NUM_SOLVERS       channel i holds a write request
// in_ack        out  NUM_SOLVERS       one-cycle pulse: channel i's write was taken
// out_data      out  DATA_W            write data at FIFO head
// out_addr      out  ADDR_W            write address at FIFO head
// out_write_en  out  1                 FIFO head valid (= FIFO not empty)
// out_ack       in   1                 memory accepted the head word this cycle
// fifo_count    out  $clog2(FIFO_DEPTH+1)  current queue occupancy
// idle          out  1                 FIFO empty and no in_ack pulse active
//
// BEHAVIOUR
// - Reset values: in_ack=0, out_write_en=0, out_data=0, out_addr=0, fifo_count=0,
//   idle=1. FIFO pointers=0, rr pointer=NUM_SOLVERS-1.
// - Reset mid-operation: all queued writes are discarded. Requesters must re-present.
// - Eligible set = in_valid & ~in_ack. A channel acked this cycle is masked, which
//   prevents a double grant while its valid is still high.
// - Grant: when eligible != 0 and fifo_count < FIFO_DEPTH, exactly one channel g is
//   chosen. At the clock edge:
//   - in_ack <= onehot(g);
//   - {in_data[g], in_addr[g]} are pushed to the FIFO tail;
//   - the rr pointer <= g.
// - No grant: in_ack <= 0. FIFO full blocks grants even if a pop happens in the
//   same cycle (no bypass).
// - Requester sees in_ack one cycle after its request was sampled. It must then
//   drop in_valid or present the next word. Data is captured at the grant edge only.
// - Throughput: 1 write/cycle aggregate; 1 write per 2 cycles per channel.
// - Output is first-word-fall-through: out_write_en, out_data and out_addr come
//   straight from the head register. Head is stable while out_write_en=1 and
//   out_ack=0.
// - Pop when out_write_en && out_ack. out_ack while empty is ignored.
// - Simultaneous push and pop: count unchanged. An empty push is visible on out_*
//   the cycle after the grant edge (latency: request sampled -> out_write_en = 1 cycle).
// - When empty, out_data/out_addr hold the last popped value.
// - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. fifo_count
//   saturates by construction: no push when full, no pop when empty.
//
// CONFIGURATION
// WRITE_ARB_ROUND_ROBIN_EN
// - Defined: round-robin grant. Search starts at rr pointer+1 (mod NUM_SOLVERS) and
//   the first eligible channel wins. A continuously requesting channel waits at most
//   NUM_SOLVERS-1 grants.
// - Undefined: fixed priority, lowest eligible index wins. The rr pointer is unused
//   and may be optimised away.
// - Handshake, FIFO and timing are identical in both builds.
//
// TESTING
// 1. Single channel: in_valid=0001, data=16'hABCD, addr=32'h100, out_ack=1 ->
//    in_ack=0001 for 1 cycle; next cycle out_write_en=1 with ABCD@100; then idle=1.
// 2. All 4 valid continuously, out_ack=1, RR build -> grant order 0,1,2,3,0,...
//    No in_ack in consecutive cycles on one channel. Fixed build -> 0,1(masked 0),0,1...
// 3. out_ack=0, all valid -> exactly 4 grants, fifo_count=4, in_ack=0 thereafter.
//    out_ack=1 for 1 cycle -> count 3, next grant follows.
// 4. FIFO full with out_ack=1 and valid pending -> that cycle pops with no grant.
//    Next cycle grants; count goes 4->3->4. Writes emerge in grant order, intact.
// 5. Reset asserted with 3 entries queued and in_ack active -> next cycle
//    out_write_en=0, in_ack=0, fifo_count=0, idle=1. First post-reset grant is channel 0.
// 6. out_ack pulsed while empty -> fifo_count stays 0, no spurious out_write_en.

Source files
------------

// File: rtl/write_arbitrator_rr_if.sv
// Bundle of solver-side write requests and the frame-buffer write port for write_arbitrator_rr.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface write_arbitrator_rr_if #(
  parameter int unsigned NUM_SOLVERS = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_SOLVERS-1:0][DATA_W-1:0] in_data;
  logic [NUM_SOLVERS-1:0][ADDR_W-1:0] in_addr;
  logic [NUM_SOLVERS-1:0]             in_valid;
  logic [NUM_SOLVERS-1:0]             in_ack;
  logic [DATA_W-1:0]                  out_data;
  logic [ADDR_W-1:0]                  out_addr;
  logic                               out_write_en;
  logic                               out_ack;
  logic [CNT_W-1:0]                   fifo_count;
  logic                               idle;

  modport master (
    output in_data, in_addr, in_valid, out_ack,
    input  in_ack, out_data, out_addr, out_write_en, fifo_count, idle
  );

  modport slave (
    input  in_data, in_addr, in_valid, out_ack,
    output in_ack, out_data, out_addr, out_write_en, fifo_count, idle
  );
endinterface

// File: rtl/write_arbitrator_rr.sv
// N-to-1 solver write arbiter feeding a first-word-fall-through output FIFO.
// Define WRITE_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise lowest index wins.
module write_arbitrator_rr #(
  parameter int unsigned NUM_SOLVERS = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic                  clock,
  input logic                  reset,
  write_arbitrator_rr_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;

  logic [DATA_W-1:0]      data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]      addr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_prev;
  logic [CNT_W-1:0]       count;
  logic [NUM_SOLVERS-1:0] ack;
  logic [NUM_SOLVERS-1:0] eligible;
  logic [NUM_SOLVERS-1:0] grant_oh;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant;
  logic                   pop;
  logic                   full;
  logic                   empty;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // A channel acked last edge may still hold valid high; mask it to avoid a double grant.
  assign eligible = bus.in_valid & ~ack;
  assign pop      = !empty && bus.out_ack;

`ifdef WRITE_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_SOLVERS; k++) begin
      cand = IDX_W'((32'(rr_ptr) + k) % NUM_SOLVERS);
      if (!grant && eligible[cand]) begin
        grant     = 1'b1;
        grant_idx = cand;
      end
    end
    // No bypass: a full FIFO blocks grants even when popping this cycle.
    if (full) grant = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= IDX_W'(NUM_SOLVERS - 1);
    end else if (grant) begin
      rr_ptr <= grant_idx;
    end
  end
`else
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_SOLVERS; k++) begin
      if (!grant && eligible[k]) begin
        grant     = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
    if (full) grant = 1'b0;
  end
`endif

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      ack <= grant_oh;
      if (grant) begin
        data_mem[wr_ptr] <= bus.in_data[grant_idx];
        addr_mem[wr_ptr] <= bus.in_addr[grant_idx];
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // When empty, the slot behind rd_ptr still holds the last popped word (zero after reset).
  assign rd_prev          = rd_ptr - PTR_W'(1);
  assign bus.out_data     = empty ? data_mem[rd_prev] : data_mem[rd_ptr];
  assign bus.out_addr     = empty ? addr_mem[rd_prev] : addr_mem[rd_ptr];
  assign bus.out_write_en = !empty;
  assign bus.fifo_count   = count;
  assign bus.in_ack       = ack;
  assign bus.idle         = empty && (ack == '0);
endmodule

// File: tb/tb_write_arbitrator_rr.sv
// Bench for write_arbitrator_rr: fixed vector table, hand sequences and random traffic
// checked against a queue-based model. Follows WRITE_ARB_ROUND_ROBIN_EN like the design.
module tb_write_arbitrator_rr;
  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  write_arbitrator_rr_if #(
    .NUM_SOLVERS(N), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) bus ();

  write_arbitrator_rr #(
    .NUM_SOLVERS(N), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
  } wr_t;

  typedef struct {
    logic [N-1:0] valid;
    logic         oack;
    logic [N-1:0] ack_rr;
    logic [N-1:0] ack_fx;
    int           cnt;
    logic         we;
    logic         idle;
  } vec_t;

  vec_t         tbl [15];
  wr_t          q[$];
  wr_t          last;
  logic [N-1:0] m_ack;
`ifdef WRITE_ARB_ROUND_ROBIN_EN
  int           m_rr;
`endif
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the reference behaviour, from the inputs about to be sampled.
  task automatic model_edge();
    logic [N-1:0] elig;
    int           g;
    if (reset) begin
      q.delete();
      last  = '0;
      m_ack = '0;
`ifdef WRITE_ARB_ROUND_ROBIN_EN
      m_rr  = N - 1;
`endif
    end else begin
      elig = bus.in_valid & ~m_ack;
      g    = -1;
      if (elig != '0 && q.size() < DEPTH) begin
`ifdef WRITE_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (g < 0 && elig[c]) g = c;
        end
`else
        for (int c = 0; c < N; c++) if (g < 0 && elig[c]) g = c;
`endif
      end
      if (q.size() > 0 && bus.out_ack) last = q.pop_front();
      m_ack = '0;
      if (g >= 0) begin
        q.push_back({bus.in_data[g], bus.in_addr[g]});
        m_ack[g] = 1'b1;
`ifdef WRITE_ARB_ROUND_ROBIN_EN
        m_rr = g;
`endif
      end
    end
  endtask

  task automatic check_model();
    wr_t head;
    head = (q.size() > 0) ? q[0] : last;
    chk("in_ack", bus.in_ack, m_ack);
    chk("fifo_count", bus.fifo_count, q.size());
    chk("out_write_en", bus.out_write_en, q.size() > 0);
    chk("out_data", bus.out_data, head.d);
    chk("out_addr", bus.out_addr, head.a);
    chk("idle", bus.idle, q.size() == 0 && m_ack == '0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    check_model();
  endtask

  task automatic fixed_data();
    for (int c = 0; c < N; c++) begin
      bus.in_data[c] = DW'(16'hA000 + c);
      bus.in_addr[c] = AW'(32'h1000 + c);
    end
  endtask

  initial begin
    // valid, out_ack, in_ack (RR build), in_ack (fixed build), count, write_en, idle
    tbl = '{
      '{4'b1111, 1'b0, 4'b0001, 4'b0001, 1, 1'b1, 1'b0},
      '{4'b1111, 1'b0, 4'b0010, 4'b0010, 2, 1'b1, 1'b0},
      '{4'b1111, 1'b0, 4'b0100, 4'b0001, 3, 1'b1, 1'b0},
      '{4'b1111, 1'b0, 4'b1000, 4'b0010, 4, 1'b1, 1'b0},
      '{4'b1111, 1'b0, 4'b0000, 4'b0000, 4, 1'b1, 1'b0},
      '{4'b1111, 1'b0, 4'b0000, 4'b0000, 4, 1'b1, 1'b0},
      '{4'b1111, 1'b1, 4'b0000, 4'b0000, 3, 1'b1, 1'b0},
      '{4'b1111, 1'b0, 4'b0001, 4'b0001, 4, 1'b1, 1'b0},
      '{4'b1111, 1'b1, 4'b0000, 4'b0000, 3, 1'b1, 1'b0},
      '{4'b1111, 1'b1, 4'b0010, 4'b0001, 3, 1'b1, 1'b0},
      '{4'b1111, 1'b1, 4'b0100, 4'b0010, 3, 1'b1, 1'b0},
      '{4'b0000, 1'b1, 4'b0000, 4'b0000, 2, 1'b1, 1'b0},
      '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1, 1'b1, 1'b0},
      '{4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 1'b0, 1'b1},
      '{4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 1'b0, 1'b1}
    };

    bus.in_valid = '0;
    bus.out_ack  = 1'b0;
    fixed_data();
    reset = 1'b1;
    step();
    step();
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_write_en", bus.out_write_en, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    reset = 1'b0;

    // Single channel write, then drain.
    bus.in_valid   = 4'b0001;
    bus.in_data[0] = 16'hABCD;
    bus.in_addr[0] = 32'h100;
    bus.out_ack    = 1'b1;
    step();
    chk("t1_ack", bus.in_ack, 4'b0001);
    chk("t1_write_en", bus.out_write_en, 1'b1);
    chk("t1_data", bus.out_data, 16'hABCD);
    chk("t1_addr", bus.out_addr, 32'h100);
    bus.in_valid = '0;
    step();
    chk("t1_ack_drop", bus.in_ack, 4'b0000);
    chk("t1_idle", bus.idle, 1'b1);
    chk("t1_hold_data", bus.out_data, 16'hABCD);

    // Table: fill to full, pop-without-grant at full, steady state, drain, empty ack.
    reset = 1'b1;
    step();
    reset = 1'b0;
    fixed_data();
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = tbl[i].valid;
      bus.out_ack  = tbl[i].oack;
      step();
`ifdef WRITE_ARB_ROUND_ROBIN_EN
      chk($sformatf("tbl%0d_ack", i), bus.in_ack, tbl[i].ack_rr);
`else
      chk($sformatf("tbl%0d_ack", i), bus.in_ack, tbl[i].ack_fx);
`endif
      chk($sformatf("tbl%0d_count", i), bus.fifo_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_write_en", i), bus.out_write_en, tbl[i].we);
      chk($sformatf("tbl%0d_idle", i), bus.idle, tbl[i].idle);
    end

    // Reset with three queued writes and an ack pulse in flight.
    bus.in_valid = 4'b1111;
    bus.out_ack  = 1'b0;
    step();
    step();
    step();
    chk("t5_count_pre", bus.fifo_count, 3);
    chk("t5_ack_active", bus.in_ack != '0, 1'b1);
    reset = 1'b1;
    step();
    chk("t5_write_en", bus.out_write_en, 1'b0);
    chk("t5_ack", bus.in_ack, 4'b0000);
    chk("t5_count", bus.fifo_count, 0);
    chk("t5_idle", bus.idle, 1'b1);
    reset = 1'b0;
    step();
    chk("t5_first_grant", bus.in_ack, 4'b0001);

    // Random traffic: light back-pressure first, heavy back-pressure later.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = N'($urandom);
      bus.out_ack  = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      for (int c = 0; c < N; c++) begin
        bus.in_data[c] = DW'($urandom);
        bus.in_addr[c] = $urandom;
      end
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
